// File: rtl/fetch_pkg.sv
// Shared types and address helpers for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    localparam int INST_BYTES = 4;
    localparam int PC_MAX_W   = 64;

    // Callers truncate the result to their own width, so the increment wraps naturally.
    function automatic logic [PC_MAX_W-1:0] next_pc(input logic [PC_MAX_W-1:0] pc);
        return pc + PC_MAX_W'(INST_BYTES);
    endfunction

    function automatic logic [PC_MAX_W-1:0] align_pc(input logic [PC_MAX_W-1:0] pc);
        return pc & ~PC_MAX_W'(INST_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_credit_ctr.sv
// Buffer-occupancy, in-flight and squash counters that gate instruction fetch issue.
module fetch_credit_ctr #(
    parameter int BUFFER_DEPTH    = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic redirect,
    input  logic req_fire,
    input  logic rsp_valid,
    input  logic buf_write,
    input  logic buf_rd_fire,
    output logic can_issue,
    output logic drop_rsp
);

    localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;

    logic [CNT_W-1:0] occ_q, outstanding_q, discard_q;
    logic [CNT_W-1:0] occ_d, outstanding_d, discard_d;
    logic [CNT_W:0]   credit_used;

    // A request may only go out if its response is guaranteed a buffer slot.
    assign credit_used = {1'b0, occ_q} + {1'b0, outstanding_q};
    assign can_issue   = run
                      && (credit_used < (CNT_W+1)'(BUFFER_DEPTH))
                      && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign drop_rsp    = (discard_q != '0);

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_valid);
        occ_d         = occ_q + CNT_W'(buf_write) - CNT_W'(buf_rd_fire);
        discard_d     = (rsp_valid && drop_rsp) ? discard_q - CNT_W'(1) : discard_q;
        if (redirect) begin
            occ_d = '0;
            // Every response still in flight after this edge belongs to the old stream,
            // which keeps back-to-back redirects from double counting.
            if (rsp_valid && (outstanding_q != '0))
                discard_d = outstanding_q - CNT_W'(1);
            else
                discard_d = outstanding_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q         <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            occ_q         <= occ_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (outstanding_q != '0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, imem request/response handshake, fault halt and redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    INST_WIDTH      = 32,
    parameter int                    BUFFER_DEPTH    = 8,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [INST_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [INST_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [INST_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  buf_write_en,
    output logic [INST_WIDTH-1:0] buf_data_in,
    input  logic                  buf_rd_fire,
    output logic                  buf_flush,
    output logic                  fetch_fault,
    output logic [INST_WIDTH-1:0] fault_pc
);

    fetch_state_t          state_q, state_d;
    logic [INST_WIDTH-1:0] pc_q, rsp_pc_q, fault_pc_q;
    logic [INST_WIDTH-1:0] pc_inc, rsp_pc_inc, redirect_pc_aligned;
    logic                  flush_q;
    logic                  can_issue, drop_rsp;
    logic                  req_fire, rsp_live, rsp_fault;

    assign pc_inc              = INST_WIDTH'(next_pc(PC_MAX_W'(pc_q)));
    assign rsp_pc_inc          = INST_WIDTH'(next_pc(PC_MAX_W'(rsp_pc_q)));
    assign redirect_pc_aligned = INST_WIDTH'(align_pc(PC_MAX_W'(redirect_pc)));

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_live  = imem_rsp_valid && !drop_rsp;
    assign rsp_fault = rsp_live && imem_rsp_err && (state_q == RUN) && !redirect_valid;

    fetch_credit_ctr #(
        .BUFFER_DEPTH    (BUFFER_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (state_q == RUN),
        .redirect    (redirect_valid),
        .req_fire    (req_fire),
        .rsp_valid   (imem_rsp_valid),
        .buf_write   (buf_write_en),
        .buf_rd_fire (buf_rd_fire),
        .can_issue   (can_issue),
        .drop_rsp    (drop_rsp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid)
            state_d = RUN;
        else if (rsp_fault)
            state_d = HALT;
    end

    // Gated by rst_n so nothing leaks to imem or the buffer while reset is held.
    always_comb begin
        imem_req_valid = rst_n && can_issue && !redirect_valid;
        buf_write_en   = rst_n && rsp_live && !imem_rsp_err
                      && (state_q == RUN) && !redirect_valid;
        fetch_fault    = (state_q == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            fault_pc_q <= '0;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= redirect_valid;
            if (redirect_valid) begin
                pc_q     <= redirect_pc_aligned;
                rsp_pc_q <= redirect_pc_aligned;
            end else begin
                if (req_fire)  pc_q       <= pc_inc;
                if (rsp_live)  rsp_pc_q   <= rsp_pc_inc;
                if (rsp_fault) fault_pc_q <= rsp_pc_q;
            end
        end
    end

    assign imem_req_addr = pc_q;
    assign buf_data_in   = imem_rsp_data;
    assign buf_flush     = flush_q;
    assign fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency instruction memory model.
module tb_fetch_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [W-1:0]  imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [W-1:0]  imem_rsp_data = '0;
    logic          imem_rsp_err = 1'b0;
    logic          buf_write_en;
    logic [W-1:0]  buf_data_in;
    logic          buf_rd_fire = 1'b0;
    logic          buf_flush;
    logic          fetch_fault;
    logic [W-1:0]  fault_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .INST_WIDTH      (W),
        .BUFFER_DEPTH    (8),
        .MAX_OUTSTANDING (4),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .buf_write_en   (buf_write_en),
        .buf_data_in    (buf_data_in),
        .buf_rd_fire    (buf_rd_fire),
        .buf_flush      (buf_flush),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    typedef struct {
        logic [W-1:0] addr;
        int           due;
    } pend_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           lat = 1;
    int           tb_occ = 0;
    int           peak = 0;
    int           n_flush = 0;
    logic         pop_mode = 1'b0;
    logic         err_en = 1'b0;
    logic [W-1:0] err_addr = '0;
    pend_t        pend[$];
    logic [W-1:0] req_log[$];
    logic [W-1:0] wr_log[$];

    function automatic logic [W-1:0] mem_data(input logic [W-1:0] a);
        return (a == 32'h0000_1000) ? 32'hDEADBEEF : ~a;
    endfunction

    // Called just after a falling edge: drive this cycle's inputs, then record what the DUT does.
    task automatic tick_begin();
        pend_t p;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(p.addr);
            imem_rsp_err   = err_en && (p.addr == err_addr);
        end
        buf_rd_fire = pop_mode && (tb_occ > 0);
        #1;
        if (imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            req_log.push_back(imem_req_addr);
        end
        if (pend.size() > peak) peak = pend.size();
        if (buf_write_en) wr_log.push_back(buf_data_in);
        if (buf_flush) n_flush++;
        tb_occ = tb_occ + (buf_write_en ? 1 : 0) - (buf_rd_fire ? 1 : 0);
        if (redirect_valid) tb_occ = 0;
    endtask

    task automatic tick_end();
        @(negedge clk);
        cyc++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_begin();
            tick_end();
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        buf_rd_fire    = 1'b0;
        pop_mode       = 1'b0;
        err_en         = 1'b0;
        pend.delete();
        req_log.delete();
        wr_log.delete();
        n_flush = 0;
        tb_occ  = 0;
        peak    = 0;
        cyc     = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [W-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5678;
        #1;
        checks++; if (buf_write_en !== 1'b0) begin errors++; $display("FAIL rst_write_en got %0b want 0", buf_write_en); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0b want 0", imem_req_valid); end
        checks++; if (buf_flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b want 0", buf_flush); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0b want 0", fetch_fault); end
        checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL rst_fault_pc got %0h want 0", fault_pc); end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL rst_rel_valid got %0b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_rel_addr got %0h want 0", imem_req_addr); end
        @(negedge clk);
    endtask

    task automatic test_fill();
        int bad;
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        tick(20);
        bad = 0;
        for (int i = 0; i < req_log.size(); i++)
            if (req_log[i] !== 32'(4 * i)) bad++;
        checks++; if (req_log.size() != 8) begin errors++; $display("FAIL fill_req_count got %0d want 8", req_log.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_req_addr got %0d bad addresses want 0", bad); end
        bad = 0;
        for (int i = 0; i < wr_log.size(); i++)
            if (wr_log[i] !== ~32'(4 * i)) bad++;
        checks++; if (wr_log.size() != 8) begin errors++; $display("FAIL fill_wr_count got %0d want 8", wr_log.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_wr_data got %0d bad words want 0", bad); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_low got %0b want 0", imem_req_valid); end
        checks++; if (dut.u_credit.occ_q !== 4'd8) begin errors++; $display("FAIL fill_occ got %0d want 8", dut.u_credit.occ_q); end
    endtask

    task automatic test_stream();
        int bad;
        do_reset();
        lat = 4;
        pop_mode = 1'b1;
        imem_req_ready = 1'b1;
        tick(40);
        bad = 0;
        for (int i = 0; i < req_log.size(); i++)
            if (req_log[i] !== 32'(4 * i)) bad++;
        checks++; if (req_log.size() != 32) begin errors++; $display("FAIL stream_req_count got %0d want 32", req_log.size()); end
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_addr_seq got %0d bad addresses want 0", bad); end
        checks++; if (peak != 4) begin errors++; $display("FAIL stream_peak_inflight got %0d want 4", peak); end
        checks++; if (dut.u_credit.occ_q !== 4'(tb_occ)) begin errors++; $display("FAIL stream_occ got %0d want %0d", dut.u_credit.occ_q, tb_occ); end
        imem_req_ready = 1'b0;
        tick(6);
        checks++; if (wr_log.size() != 32) begin errors++; $display("FAIL stream_wr_count got %0d want 32", wr_log.size()); end
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 6;
        imem_req_ready = 1'b1;
        tick(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        tick_begin();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_issue got %0b want 0", imem_req_valid); end
        tick_end();
        redirect_valid = 1'b0;
        tick_begin();
        checks++; if (buf_flush !== 1'b1) begin errors++; $display("FAIL redir_flush got %0b want 1", buf_flush); end
        checks++; if (imem_req_addr !== 32'h0000_1000) begin errors++; $display("FAIL redir_addr got %0h want 1000", imem_req_addr); end
        tick_end();
        imem_req_ready = 1'b0;
        tick_begin();
        checks++; if (buf_flush !== 1'b0) begin errors++; $display("FAIL redir_flush_end got %0b want 0", buf_flush); end
        tick_end();
        tick(9);
        checks++; if (n_flush != 1) begin errors++; $display("FAIL redir_flush_count got %0d want 1", n_flush); end
        checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL redir_wr_count got %0d want 1", wr_log.size()); end
        if (wr_log.size() > 0) begin
            checks++; if (wr_log[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL redir_wr_data got %0h want deadbeef", wr_log[0]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = 5;
        imem_req_ready = 1'b1;
        tick(2);
        redirect_to(32'h0000_0100);
        redirect_to(32'h0000_0200);
        tick_begin();
        checks++; if (imem_req_addr !== 32'h0000_0200) begin errors++; $display("FAIL b2b_addr got %0h want 200", imem_req_addr); end
        tick_end();
        imem_req_ready = 1'b0;
        tick(8);
        checks++; if (n_flush != 2) begin errors++; $display("FAIL b2b_flush_count got %0d want 2", n_flush); end
        checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL b2b_wr_count got %0d want 1", wr_log.size()); end
        if (wr_log.size() > 0) begin
            checks++; if (wr_log[0] !== ~32'h0000_0200) begin errors++; $display("FAIL b2b_wr_data got %0h want %0h", wr_log[0], ~32'h0000_0200); end
        end
    endtask

    task automatic test_fault();
        do_reset();
        lat = 1;
        err_en   = 1'b1;
        err_addr = 32'h0000_0048;
        imem_req_ready = 1'b1;
        redirect_to(32'h0000_0040);
        req_log.delete();
        wr_log.delete();
        tick(8);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %0b want 1", fetch_fault); end
        checks++; if (fault_pc !== 32'h0000_0048) begin errors++; $display("FAIL fault_pc got %0h want 48", fault_pc); end
        checks++; if (req_log.size() != 4) begin errors++; $display("FAIL fault_req_count got %0d want 4", req_log.size()); end
        checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL fault_wr_count got %0d want 2", wr_log.size()); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fault_no_issue got %0b want 0", imem_req_valid); end
        imem_req_ready = 1'b0;
        redirect_to(32'h0000_0080);
        tick_begin();
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %0b want 0", fetch_fault); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL fault_resume_valid got %0b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0000_0080) begin errors++; $display("FAIL fault_resume_addr got %0h want 80", imem_req_addr); end
        tick_end();
        err_en = 1'b0;
        tick(2);
    endtask

    task automatic test_stall();
        do_reset();
        lat = 1;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_begin();
            checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b want 1", i, imem_req_valid); end
            checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL stall_addr[%0d] got %0h want 0", i, imem_req_addr); end
            tick_end();
        end
        imem_req_ready = 1'b1;
        tick(1);
        imem_req_ready = 1'b0;
        tick_begin();
        checks++; if (imem_req_addr !== 32'h4) begin errors++; $display("FAIL stall_advance got %0h want 4", imem_req_addr); end
        tick_end();
        checks++; if (req_log.size() != 1) begin errors++; $display("FAIL stall_req_count got %0d want 1", req_log.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        redirect_to(32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        tick_begin();
        checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %0h want fffffffc", imem_req_addr); end
        tick_end();
        imem_req_ready = 1'b0;
        tick_begin();
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %0h want 0", imem_req_addr); end
        tick_end();
        tick(1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 2;
        err_en   = 1'b1;
        err_addr = 32'h0000_0008;
        imem_req_ready = 1'b1;
        tick(5);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL mid_pre_fault got %0b want 1", fetch_fault); end
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL mid_addr got %0h want 0", imem_req_addr); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", imem_req_valid); end
        checks++; if (buf_write_en !== 1'b0) begin errors++; $display("FAIL mid_write_en got %0b want 0", buf_write_en); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL mid_fault got %0b want 0", fetch_fault); end
        checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL mid_fault_pc got %0h want 0", fault_pc); end
        checks++; if (buf_flush !== 1'b0) begin errors++; $display("FAIL mid_flush got %0b want 0", buf_flush); end
        checks++; if (dut.u_credit.outstanding_q !== 4'd0) begin errors++; $display("FAIL mid_outstanding got %0d want 0", dut.u_credit.outstanding_q); end
        checks++; if (dut.u_credit.occ_q !== 4'd0) begin errors++; $display("FAIL mid_occ got %0d want 0", dut.u_credit.occ_q); end
        @(negedge clk);
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_back_to_back();
        test_fault();
        test_stall();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
